// File: rtl/fp_mat_pkg.sv
// Shared definitions for the packed fixed-point matrix blocks: FSM encoding,
// index-width derivation and the element bit-offset helper.
package fp_mat_pkg;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StStream = 1'b1
  } state_e;

  // Index width that stays at least one bit even for a single-entry dimension.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // LSB of element (i,j) within a row-major packed matrix of `cols` columns.
  function automatic int unsigned elem_lsb(input int unsigned i, input int unsigned j,
                                           input int unsigned cols, input int unsigned dw);
    return dw * (i * cols + j);
  endfunction

endpackage

// File: rtl/fp_mat_idx_counter.sv
// 2-D (row, col) index counter that walks a ROW x COL matrix in row-major or
// column-major order, wrapping at the true dimension.
module fp_mat_idx_counter
  import fp_mat_pkg::*;
#(
  parameter int unsigned ROW = 8,
  parameter int unsigned COL = 8,
  localparam int unsigned ROW_IDX_W = idx_w(ROW),
  localparam int unsigned COL_IDX_W = idx_w(COL)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 advance,
  input  logic                 col_major,
  output logic [ROW_IDX_W-1:0] row,
  output logic [COL_IDX_W-1:0] col,
  output logic                 at_last
);

  localparam logic [ROW_IDX_W-1:0] RowMax = ROW_IDX_W'(ROW - 1);
  localparam logic [COL_IDX_W-1:0] ColMax = COL_IDX_W'(COL - 1);

  logic [ROW_IDX_W-1:0] row_q, row_d;
  logic [COL_IDX_W-1:0] col_q, col_d;
  logic                 row_wrap, col_wrap;

  assign row_wrap = (row_q == RowMax);
  assign col_wrap = (col_q == ColMax);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (!col_major) begin
        col_d = col_wrap ? '0 : col_q + 1'b1;
        if (col_wrap) row_d = row_wrap ? '0 : row_q + 1'b1;
      end else begin
        row_d = row_wrap ? '0 : row_q + 1'b1;
        if (row_wrap) col_d = col_wrap ? '0 : col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row     = row_q;
  assign col     = col_q;
  assign at_last = row_wrap && col_wrap;

endmodule

// File: rtl/fp_mat_serializer.sv
// Captures one packed ROW x COL fixed-point matrix and streams it out one
// element per cycle with indices and a last flag.
module fp_mat_serializer
  import fp_mat_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ROW = 8,
  parameter int unsigned COL = 8,
  localparam int unsigned ROW_IDX_W = idx_w(ROW),
  localparam int unsigned COL_IDX_W = idx_w(COL)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH*ROW*COL-1:0]  in_mat,
  input  logic                           in_col_major,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [ROW_IDX_W-1:0]           out_row,
  output logic [COL_IDX_W-1:0]           out_col,
  output logic                           out_last,
  output logic                           busy
);

  localparam int unsigned MatW = DATA_WIDTH * ROW * COL;

  state_e                state_q, state_d;
  logic [MatW-1:0]       mat_q;
  logic                  col_major_q;
  logic                  load, fire, at_last;
  logic [DATA_WIDTH-1:0] elem [ROW][COL];

  assign out_valid = (state_q == StStream);
  assign busy      = out_valid;
  assign fire      = out_valid && out_ready;
  assign out_last  = out_valid && at_last;
  // Accepting on the final handshake lets a new matrix follow with no bubble.
  assign in_ready  = rst_n && ((state_q == StIdle) || (fire && at_last));
  assign load      = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = StStream;
    end else if (fire && at_last) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Matrix storage is deliberately not reset; it is only read while streaming.
  always_ff @(posedge clk) begin
    if (load) begin
      mat_q       <= in_mat;
      col_major_q <= in_col_major;
    end
  end

  fp_mat_idx_counter #(
    .ROW (ROW),
    .COL (COL)
  ) u_idx_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (load),
    .advance   (fire),
    .col_major (col_major_q),
    .row       (out_row),
    .col       (out_col),
    .at_last   (at_last)
  );

  for (genvar gi = 0; gi < ROW; gi++) begin : g_row
    for (genvar gj = 0; gj < COL; gj++) begin : g_col
      assign elem[gi][gj] = mat_q[elem_lsb(gi, gj, COL, DATA_WIDTH) +: DATA_WIDTH];
    end
  end

  assign out_data = elem[out_row][out_col];

endmodule

// File: tb/tb_fp_mat_serializer.sv
// Self-checking bench for fp_mat_serializer with a 2x3 matrix: queue-based
// reference model checked every cycle plus literal expectations per scenario.
module tb_fp_mat_serializer;

  localparam int DW = 16;
  localparam int R  = 2;
  localparam int C  = 3;
  localparam int N  = R * C;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DW*N-1:0]   in_mat;
  logic              in_col_major;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [0:0]        out_row;
  logic [1:0]        out_col;
  logic              out_last;
  logic              busy;

  fp_mat_serializer #(
    .DATA_WIDTH (DW),
    .ROW        (R),
    .COL        (C)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mat       (in_mat),
    .in_col_major (in_col_major),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_row      (out_row),
    .out_col      (out_col),
    .out_last     (out_last),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    int            r;
    int            c;
    bit            l;
  } exp_t;

  exp_t          mq[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  bit            live     = 1'b0;
  logic [DW-1:0] got_d[$];
  int            got_r[$];
  int            got_c[$];
  bit            got_l[$];
  int            valid_cycles, run, max_run;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_in_ready();
    return rst_n && (mq.size() == 0 || (mq.size() == 1 && out_ready));
  endfunction

  // Reference model: a load enqueues the whole matrix in the requested order.
  always @(posedge clk) begin
    bit rdy;
    if (!rst_n) begin
      live = 1'b1;
      mq.delete();
    end else begin
      rdy = exp_in_ready();
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      if (in_valid && rdy) begin
        if (!in_col_major) begin
          for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++)
              mq.push_back('{in_mat[DW*(i*C+j) +: DW], i, j, (i == R-1 && j == C-1)});
        end else begin
          for (int j = 0; j < C; j++)
            for (int i = 0; i < R; i++)
              mq.push_back('{in_mat[DW*(i*C+j) +: DW], i, j, (i == R-1 && j == C-1)});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("in_ready", 32'(in_ready), 32'(exp_in_ready()));
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("busy", 32'(busy), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("out_data", 32'(out_data), 32'(mq[0].d));
        chk("out_row", 32'(out_row), 32'(mq[0].r));
        chk("out_col", 32'(out_col), 32'(mq[0].c));
        chk("out_last", 32'(out_last), 32'(mq[0].l));
      end else begin
        chk("out_last_idle", 32'(out_last), 32'd0);
      end
      if (out_valid === 1'b1) begin
        valid_cycles++;
        run++;
        if (run > max_run) max_run = run;
        if (out_ready) begin
          got_d.push_back(out_data);
          got_r.push_back(int'(out_row));
          got_c.push_back(int'(out_col));
          got_l.push_back(out_last);
        end
      end else begin
        run = 0;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    got_d.delete();
    got_r.delete();
    got_c.delete();
    got_l.delete();
    valid_cycles = 0;
    run = 0;
    max_run = 0;
  endtask

  // Present a matrix for one cycle; the block is idle whenever this is used.
  task automatic load(input logic [DW*N-1:0] m, input logic cm);
    in_valid     = 1'b1;
    in_mat       = m;
    in_col_major = cm;
    step();
    in_valid = 1'b0;
  endtask

  logic [DW*N-1:0] m1, m2;
  logic [DW-1:0]   lit_rm [6] = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0105};
  logic [DW-1:0]   lit_cm [6] = '{16'h0100, 16'h0103, 16'h0101, 16'h0104, 16'h0102, 16'h0105};
  int              lit_rm_r [6] = '{0, 0, 0, 1, 1, 1};
  int              lit_rm_c [6] = '{0, 1, 2, 0, 1, 2};
  int              lit_cm_r [6] = '{0, 1, 0, 1, 0, 1};
  int              lit_cm_c [6] = '{0, 0, 1, 1, 2, 2};
  int              held;

  initial begin
    for (int k = 0; k < N; k++) begin
      m1[DW*k +: DW] = 16'h0100 + 16'(k);
      m2[DW*k +: DW] = 16'hFF00 + 16'(k);
    end
    rst_n        = 1'b0;
    in_valid     = 1'b1;
    in_mat       = m1;
    in_col_major = 1'b0;
    out_ready    = 1'b1;
    clear_log();

    // Reset held for two edges with in_valid asserted.
    step(2);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_idx", {31'd0, out_row, out_col}, 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    step();

    // Row-major, no backpressure.
    clear_log();
    load(m1, 1'b0);
    step(8);
    chk("rm_count", got_d.size(), 32'd6);
    for (int i = 0; i < got_d.size() && i < 6; i++) begin
      chk("rm_data", 32'(got_d[i]), 32'(lit_rm[i]));
      chk("rm_row", got_r[i], lit_rm_r[i]);
      chk("rm_col", got_c[i], lit_rm_c[i]);
      chk("rm_last", 32'(got_l[i]), 32'(i == 5));
    end
    chk("rm_valid_cycles", valid_cycles, 32'd6);

    // Column-major, same matrix.
    clear_log();
    load(m1, 1'b1);
    step(8);
    chk("cm_count", got_d.size(), 32'd6);
    for (int i = 0; i < got_d.size() && i < 6; i++) begin
      chk("cm_data", 32'(got_d[i]), 32'(lit_cm[i]));
      chk("cm_row", got_r[i], lit_cm_r[i]);
      chk("cm_col", got_c[i], lit_cm_c[i]);
      chk("cm_last", 32'(got_l[i]), 32'(i == 5));
    end

    // Backpressure: stall three cycles on the second element.
    clear_log();
    load(m1, 1'b0);
    step();
    out_ready = 1'b0;
    held = 0;
    for (int k = 0; k < 4; k++) begin
      #3;
      if (out_data === 16'h0101 && out_row === 1'b0 && out_col === 2'd1) held++;
      step();
      if (k == 2) out_ready = 1'b1;
    end
    step(6);
    chk("bp_held_cycles", held, 32'd4);
    chk("bp_valid_cycles", valid_cycles, 32'd9);
    chk("bp_count", got_d.size(), 32'd6);
    for (int i = 0; i < got_d.size() && i < 6; i++)
      chk("bp_data", 32'(got_d[i]), 32'(lit_rm[i]));

    // Back-to-back: second matrix waits with in_valid high.
    clear_log();
    in_valid     = 1'b1;
    in_mat       = m1;
    in_col_major = 1'b0;
    step();
    in_mat = m2;
    step(6);
    in_valid = 1'b0;
    step(8);
    chk("b2b_valid_cycles", valid_cycles, 32'd12);
    chk("b2b_max_run", max_run, 32'd12);
    chk("b2b_count", got_d.size(), 32'd12);
    for (int i = 0; i < got_d.size() && i < 12; i++)
      chk("b2b_data", 32'(got_d[i]), (i < 6) ? 32'(lit_rm[i]) : 32'h0000FF00 + 32'(i - 6));

    // Reset mid-stream after two elements, then reload.
    clear_log();
    load(m1, 1'b0);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_got", got_d.size(), 32'd2);
    clear_log();
    load(m2, 1'b0);
    #3;
    chk("reload_first_data", 32'(out_data), 32'h0000FF00);
    chk("reload_first_idx", {31'd0, out_row, out_col}, 32'd0);
    step(7);
    chk("reload_count", got_d.size(), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
